// File: rtl/rv32i_types.sv
// Shared RV32I definitions: opcode constants and the branch reservation-station
// entry that travels from dispatch to branch execute.
package rv32i_types;

  localparam int ROB_ID_W = 4;
  // Widest physical tag any PRF configuration uses; narrower tags zero-extend.
  localparam int PR_W     = 6;

  localparam logic [6:0] op_br   = 7'b1100011;
  localparam logic [6:0] op_jal  = 7'b1101111;
  localparam logic [6:0] op_jalr = 7'b1100111;

  typedef struct packed {
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [31:0]         pc;
    logic [31:0]         pc_next;
    logic [31:0]         imm_val;
    logic [ROB_ID_W-1:0] rob_id;
    logic [PR_W-1:0]     pr1_s;
    logic [PR_W-1:0]     pr2_s;
    logic                br_rs1_s_valid;
    logic                br_rs2_s_valid;
    logic                br_output_valid;
  } res_station_br_out_s;

  // A source is usable once woken, when it is not read at all, or when it is x0.
  function automatic logic src_ready(input logic rdy, input logic used,
                                     input logic [PR_W-1:0] tag);
    return rdy || !used || (tag == '0);
  endfunction

endpackage

// File: rtl/br_res_station_if.sv
// Dispatch, wakeup, flush and issue signals of the branch reservation station.
interface br_res_station_if import rv32i_types::*; #(
  parameter int CDB_PORTS = 2,
  parameter int PHY_WIDTH = 6
);
  logic                                 disp_valid;
  res_station_br_out_s                  disp_entry;
  logic                                 disp_ps1_rdy;
  logic                                 disp_ps2_rdy;
  logic                                 disp_ready;
  logic [CDB_PORTS-1:0]                 cdb_valid;
  logic [CDB_PORTS-1:0][PHY_WIDTH-1:0]  cdb_pd;
  logic                                 flush;
  res_station_br_out_s                  exec_br_rs;

  modport master (
    output disp_valid, disp_entry, disp_ps1_rdy, disp_ps2_rdy,
    output cdb_valid, cdb_pd, flush,
    input  disp_ready, exec_br_rs
  );

  modport slave (
    input  disp_valid, disp_entry, disp_ps1_rdy, disp_ps2_rdy,
    input  cdb_valid, cdb_pd, flush,
    output disp_ready, exec_br_rs
  );
endinterface

// File: rtl/br_rs_select.sv
// Priority encoder: lowest-index requesting entry, which in a collapsing queue is the oldest.
module br_rs_select #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);
  always_comb begin
    // NOTE: defaults before the loop keep this purely combinational (no latch).
    idx = '0;
    hit = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/br_res_station.sv
// Branch reservation station: collapsing queue with CDB wakeup and in-age-order
// single issue into a registered exec_br_rs slot.
module br_res_station import rv32i_types::*; #(
  parameter int DEPTH       = 4,
  parameter int NO_PHY_REGS = 64,
  parameter int CDB_PORTS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  br_res_station_if.slave  rs
);
  localparam int PHY_WIDTH = $clog2(NO_PHY_REGS);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(DEPTH + 1);

  res_station_br_out_s                 ent   [DEPTH];
  res_station_br_out_s                 n_ent [DEPTH];
  res_station_br_out_s                 exec_q;
  logic [DEPTH-1:0]                    valid, rdy1, rdy2;
  logic [DEPTH-1:0]                    n_valid, n_rdy1, n_rdy2;
  logic [DEPTH-1:0]                    wake1, wake2, ready_vec;
  logic [CNT_W-1:0]                    count, n_count, wr_idx;
  logic [IDX_W-1:0]                    sel_idx;
  logic                                hit, accept, disp_ready;
  logic                                disp_wake1, disp_wake2;
  logic [CDB_PORTS-1:0][PHY_WIDTH-1:0] cdb_tag;

  assign cdb_tag       = rs.cdb_pd;
  assign disp_ready    = count < CNT_W'(DEPTH);
  assign accept        = rs.disp_valid && disp_ready;
  // An issue this cycle frees the slot below the tail, so the newcomer lands there.
  assign wr_idx        = count - CNT_W'(hit);
  assign rs.disp_ready = disp_ready;
  assign rs.exec_br_rs = exec_q;

  // Wakeups take effect at the edge; selection only sees registered ready bits.
  always_comb begin : wakeup
    wake1      = rdy1;
    wake2      = rdy2;
    disp_wake1 = rs.disp_ps1_rdy;
    disp_wake2 = rs.disp_ps2_rdy;
    for (int k = 0; k < CDB_PORTS; k++) begin
      if (rs.cdb_valid[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (PR_W'(cdb_tag[k]) == ent[i].pr1_s) wake1[i] = 1'b1;
          if (PR_W'(cdb_tag[k]) == ent[i].pr2_s) wake2[i] = 1'b1;
        end
        if (PR_W'(cdb_tag[k]) == rs.disp_entry.pr1_s) disp_wake1 = 1'b1;
        if (PR_W'(cdb_tag[k]) == rs.disp_entry.pr2_s) disp_wake2 = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = valid[i]
                  && src_ready(rdy1[i], ent[i].br_rs1_s_valid, ent[i].pr1_s)
                  && src_ready(rdy2[i], ent[i].br_rs2_s_valid, ent[i].pr2_s);
    end
  end

  br_rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
    .req (ready_vec),
    .idx (sel_idx),
    .hit (hit)
  );

  always_comb begin : queue_next
    n_valid = valid;
    n_rdy1  = wake1;
    n_rdy2  = wake2;
    n_ent   = ent;
    if (hit) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel_idx)) begin
          n_valid[i] = valid[i+1];
          n_rdy1[i]  = wake1[i+1];
          n_rdy2[i]  = wake2[i+1];
          n_ent[i]   = ent[i+1];
        end
      end
      n_valid[DEPTH-1] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && wr_idx == CNT_W'(i)) begin
        n_valid[i] = 1'b1;
        n_ent[i]   = rs.disp_entry;
        n_rdy1[i]  = disp_wake1;
        n_rdy2[i]  = disp_wake2;
      end
    end
    n_count = wr_idx + CNT_W'(accept);
  end

  // NOTE: payload and ready bits carry no reset; every use is qualified by valid.
  always_ff @(posedge clk) begin
    ent  <= n_ent;
    rdy1 <= n_rdy1;
    rdy2 <= n_rdy2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= '0;
      count  <= '0;
      exec_q <= '0;
    end else if (rs.flush) begin
      valid                  <= '0;
      count                  <= '0;
      exec_q.br_output_valid <= 1'b0;
    end else begin
      valid <= n_valid;
      count <= n_count;
      if (hit) begin
        exec_q                 <= ent[sel_idx];
        exec_q.br_output_valid <= 1'b1;
      end else begin
        exec_q.br_output_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_br_res_station.sv
// Self-checking bench for br_res_station: scenario tasks plus an issue-order scoreboard.
module tb_br_res_station;
  import rv32i_types::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  res_station_br_out_s exp_q[$];
  res_station_br_out_s exp_e;

  br_res_station_if #(.CDB_PORTS(2), .PHY_WIDTH(6)) rs ();

  br_res_station #(.DEPTH(4), .NO_PHY_REGS(64), .CDB_PORTS(2)) dut (
    .clk (clk),
    .rst (rst),
    .rs  (rs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary by time limit, want finish");
    $fatal(1);
  end

  // Scoreboard consumer: every issued entry must be the next expected one.
  always @(negedge clk) begin
    if (rst && rs.exec_br_rs.br_output_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got issue rob=%0d, want no issue", rs.exec_br_rs.rob_id);
      end else begin
        exp_e = exp_q.pop_front();
        if (rs.exec_br_rs !== exp_e) begin
          failures++;
          $display("FAIL sb_payload: got %h, want %h", rs.exec_br_rs, exp_e);
        end
      end
    end
  end

  function automatic res_station_br_out_s mk(input logic [6:0] op, input logic [3:0] rob,
                                             input logic [5:0] p1, input logic [5:0] p2,
                                             input logic v1, input logic v2);
    res_station_br_out_s e;
    e                 = '0;
    e.opcode          = op;
    e.funct3          = 3'b001;
    e.pc              = 32'h0000_1000 + (32'(rob) << 2);
    e.pc_next         = e.pc + 32'd4;
    e.imm_val         = 32'(rob) << 4;
    e.rob_id          = rob;
    e.pr1_s           = p1;
    e.pr2_s           = p2;
    e.br_rs1_s_valid  = v1;
    e.br_rs2_s_valid  = v2;
    return e;
  endfunction

  function automatic res_station_br_out_s issued(input res_station_br_out_s e);
    res_station_br_out_s r;
    r                 = e;
    r.br_output_valid = 1'b1;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rs.disp_valid   = 1'b0;
    rs.disp_entry   = '0;
    rs.disp_ps1_rdy = 1'b0;
    rs.disp_ps2_rdy = 1'b0;
    rs.cdb_valid    = '0;
    rs.cdb_pd       = '0;
    rs.flush        = 1'b0;
  endtask

  task automatic drive_disp(input res_station_br_out_s e, input logic r1, input logic r2);
    rs.disp_valid   = 1'b1;
    rs.disp_entry   = e;
    rs.disp_ps1_rdy = r1;
    rs.disp_ps2_rdy = r2;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    #3;
    checks++;
    if (rs.exec_br_rs !== '0) begin
      failures++;
      $display("FAIL reset_exec: got %h, want 0", rs.exec_br_rs);
    end
    checks++;
    if (rs.disp_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b, want 1", rs.disp_ready);
    end
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b0 || rs.disp_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: got valid=%b ready=%b, want valid=0 ready=1",
               rs.exec_br_rs.br_output_valid, rs.disp_ready);
    end
  endtask

  task automatic test_wakeup();
    res_station_br_out_s e;
    e = mk(op_br, 4'd1, 6'd5, 6'd6, 1'b1, 1'b1);
    drive_disp(e, 1'b1, 1'b0);
    exp_q.push_back(issued(e));
    cyc();
    drive_idle();
    repeat (2) begin
      checks++;
      if (rs.exec_br_rs.br_output_valid !== 1'b0) begin
        failures++;
        $display("FAIL wakeup_wait: got valid=%b, want 0", rs.exec_br_rs.br_output_valid);
      end
      cyc();
    end
    rs.cdb_valid = 2'b01;
    rs.cdb_pd[0] = 6'd6;
    cyc();
    drive_idle();
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b0) begin
      failures++;
      $display("FAIL wakeup_no_bypass: got valid=%b, want 0", rs.exec_br_rs.br_output_valid);
    end
    cyc();
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b1 || rs.exec_br_rs.rob_id !== 4'd1) begin
      failures++;
      $display("FAIL wakeup_issue: got valid=%b rob=%0d, want valid=1 rob=1",
               rs.exec_br_rs.br_output_valid, rs.exec_br_rs.rob_id);
    end
    repeat (2) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL wakeup_drain: got %0d pending, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_out_of_order();
    res_station_br_out_s a, b;
    a = mk(op_br, 4'd2, 6'd10, 6'd0, 1'b1, 1'b0);
    b = mk(op_br, 4'd3, 6'd11, 6'd0, 1'b1, 1'b0);
    drive_disp(a, 1'b0, 1'b0);
    cyc();
    drive_disp(b, 1'b1, 1'b0);
    exp_q.push_back(issued(b));
    cyc();
    drive_idle();
    rs.cdb_valid = 2'b01;
    rs.cdb_pd[0] = 6'd10;
    exp_q.push_back(issued(a));
    cyc();
    drive_idle();
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b1 || rs.exec_br_rs.rob_id !== 4'd3) begin
      failures++;
      $display("FAIL ooo_first: got valid=%b rob=%0d, want valid=1 rob=3",
               rs.exec_br_rs.br_output_valid, rs.exec_br_rs.rob_id);
    end
    cyc();
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b1 || rs.exec_br_rs.rob_id !== 4'd2) begin
      failures++;
      $display("FAIL ooo_second: got valid=%b rob=%0d, want valid=1 rob=2",
               rs.exec_br_rs.br_output_valid, rs.exec_br_rs.rob_id);
    end
    cyc();
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL ooo_drain: got valid=%b pending=%0d, want valid=0 pending=0",
               rs.exec_br_rs.br_output_valid, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_full();
    res_station_br_out_s e;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rs.disp_ready !== 1'b1) begin
        failures++;
        $display("FAIL full_fill_ready%0d: got %b, want 1", i, rs.disp_ready);
      end
      e = mk(op_br, 4'(4 + i), 6'(20 + i), 6'd0, 1'b1, 1'b0);
      drive_disp(e, 1'b0, 1'b0);
      exp_q.push_back(issued(e));
      cyc();
    end
    drive_idle();
    checks++;
    if (rs.disp_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready_low: got %b, want 0", rs.disp_ready);
    end
    drive_disp(mk(op_jal, 4'd8, 6'd0, 6'd0, 1'b0, 1'b0), 1'b0, 1'b0);
    cyc();
    drive_idle();
    checks++;
    if (rs.disp_ready !== 1'b0 || rs.exec_br_rs.br_output_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_drop: got ready=%b valid=%b, want ready=0 valid=0",
               rs.disp_ready, rs.exec_br_rs.br_output_valid);
    end
    rs.cdb_valid = 2'b11;
    rs.cdb_pd[0] = 6'd20;
    rs.cdb_pd[1] = 6'd21;
    cyc();
    rs.cdb_pd[0] = 6'd22;
    rs.cdb_pd[1] = 6'd23;
    cyc();
    drive_idle();
    checks++;
    if (rs.disp_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_ready_after_issue: got %b, want 1", rs.disp_ready);
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (rs.exec_br_rs.br_output_valid !== 1'b1 || rs.exec_br_rs.rob_id !== 4'(4 + j)) begin
        failures++;
        $display("FAIL full_order%0d: got valid=%b rob=%0d, want valid=1 rob=%0d", j,
                 rs.exec_br_rs.br_output_valid, rs.exec_br_rs.rob_id, 4 + j);
      end
      cyc();
    end
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL full_drain: got valid=%b pending=%0d, want valid=0 pending=0",
               rs.exec_br_rs.br_output_valid, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_flush();
    res_station_br_out_s e;
    drive_disp(mk(op_jal, 4'd9, 6'd0, 6'd0, 1'b0, 1'b0), 1'b0, 1'b0);
    rs.flush = 1'b1;
    cyc();
    drive_idle();
    repeat (2) begin
      checks++;
      if (rs.exec_br_rs.br_output_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_jal: got valid=%b, want 0", rs.exec_br_rs.br_output_valid);
      end
      cyc();
    end
    drive_disp(mk(op_jalr, 4'd10, 6'd40, 6'd0, 1'b1, 1'b0), 1'b0, 1'b0);
    cyc();
    drive_idle();
    rs.flush = 1'b1;
    cyc();
    drive_idle();
    rs.cdb_valid = 2'b01;
    rs.cdb_pd[0] = 6'd40;
    cyc();
    drive_idle();
    repeat (2) begin
      cyc();
      checks++;
      if (rs.exec_br_rs.br_output_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_pending: got valid=%b, want 0", rs.exec_br_rs.br_output_valid);
      end
    end
    e = mk(op_br, 4'd11, 6'd0, 6'd0, 1'b1, 1'b1);
    drive_disp(e, 1'b0, 1'b0);
    exp_q.push_back(issued(e));
    cyc();
    drive_idle();
    cyc();
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b1 || rs.exec_br_rs.rob_id !== 4'd11) begin
      failures++;
      $display("FAIL flush_recover: got valid=%b rob=%0d, want valid=1 rob=11",
               rs.exec_br_rs.br_output_valid, rs.exec_br_rs.rob_id);
    end
    cyc();
    exp_q.delete();
  endtask

  task automatic test_cdb_dispatch();
    res_station_br_out_s e;
    e = mk(op_br, 4'd12, 6'd9, 6'd0, 1'b1, 1'b0);
    drive_disp(e, 1'b0, 1'b0);
    rs.cdb_valid = 2'b10;
    rs.cdb_pd[1] = 6'd9;
    exp_q.push_back(issued(e));
    cyc();
    drive_idle();
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b0) begin
      failures++;
      $display("FAIL cdb_disp_early: got valid=%b, want 0", rs.exec_br_rs.br_output_valid);
    end
    cyc();
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b1 || rs.exec_br_rs.rob_id !== 4'd12) begin
      failures++;
      $display("FAIL cdb_disp_issue: got valid=%b rob=%0d, want valid=1 rob=12",
               rs.exec_br_rs.br_output_valid, rs.exec_br_rs.rob_id);
    end
    cyc();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    res_station_br_out_s e;
    for (int i = 0; i < 3; i++) begin
      e = mk(op_br, 4'(13 + i), 6'd0, 6'd0, 1'b0, 1'b0);
      drive_disp(e, 1'b0, 1'b0);
      exp_q.push_back(issued(e));
      cyc();
      if (i > 0) begin
        checks++;
        if (rs.exec_br_rs.br_output_valid !== 1'b1 || rs.exec_br_rs.rob_id !== 4'(12 + i)) begin
          failures++;
          $display("FAIL b2b_issue%0d: got valid=%b rob=%0d, want valid=1 rob=%0d", i,
                   rs.exec_br_rs.br_output_valid, rs.exec_br_rs.rob_id, 12 + i);
        end
      end
    end
    drive_idle();
    cyc();
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b1 || rs.exec_br_rs.rob_id !== 4'd15) begin
      failures++;
      $display("FAIL b2b_last: got valid=%b rob=%0d, want valid=1 rob=15",
               rs.exec_br_rs.br_output_valid, rs.exec_br_rs.rob_id);
    end
    cyc();
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: got valid=%b pending=%0d, want valid=0 pending=0",
               rs.exec_br_rs.br_output_valid, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    res_station_br_out_s e;
    for (int i = 0; i < 3; i++) begin
      drive_disp(mk(op_br, 4'(1 + i), 6'(30 + i), 6'd0, 1'b1, 1'b0), 1'b0, 1'b0);
      cyc();
    end
    e = mk(op_jal, 4'd4, 6'd0, 6'd0, 1'b0, 1'b0);
    drive_disp(e, 1'b0, 1'b0);
    exp_q.push_back(issued(e));
    cyc();
    drive_idle();
    cyc();
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b1 || rs.exec_br_rs.rob_id !== 4'd4) begin
      failures++;
      $display("FAIL rstmid_pre: got valid=%b rob=%0d, want valid=1 rob=4",
               rs.exec_br_rs.br_output_valid, rs.exec_br_rs.rob_id);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b0 || rs.disp_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_async: got valid=%b ready=%b, want valid=0 ready=1",
               rs.exec_br_rs.br_output_valid, rs.disp_ready);
    end
    exp_q.delete();
    repeat (2) cyc();
    rst = 1'b1;
    rs.cdb_valid = 2'b11;
    rs.cdb_pd[0] = 6'd30;
    rs.cdb_pd[1] = 6'd31;
    cyc();
    rs.cdb_pd[0] = 6'd32;
    cyc();
    drive_idle();
    repeat (3) begin
      cyc();
      checks++;
      if (rs.exec_br_rs.br_output_valid !== 1'b0 || rs.disp_ready !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_discard: got valid=%b ready=%b, want valid=0 ready=1",
                 rs.exec_br_rs.br_output_valid, rs.disp_ready);
      end
    end
    e = mk(op_br, 4'd5, 6'd0, 6'd0, 1'b1, 1'b1);
    drive_disp(e, 1'b0, 1'b0);
    exp_q.push_back(issued(e));
    cyc();
    drive_idle();
    cyc();
    checks++;
    if (rs.exec_br_rs.br_output_valid !== 1'b1 || rs.exec_br_rs.rob_id !== 4'd5) begin
      failures++;
      $display("FAIL rstmid_after: got valid=%b rob=%0d, want valid=1 rob=5",
               rs.exec_br_rs.br_output_valid, rs.exec_br_rs.rob_id);
    end
    cyc();
    exp_q.delete();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive_idle();
    test_reset();
    test_wakeup();
    test_out_of_order();
    test_full();
    test_flush();
    test_cdb_dispatch();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
